// File: rtl/usensor_pkg.sv
// Shared definitions for the ultrasonic sensor echo model and its ranging controller.
// Latency: n/a (constants, state encodings and a pure width function).
// Backpressure: n/a.
package usensor_pkg;

    // Echo width register size: 400*2900 = 1160000 and 1900000 both fit below 2^21.
    localparam int unsigned ECHO_W = 21;

    // Default timing constants, shared with the ranging controller's decode.
    localparam int unsigned CYCLES_PER_CM   = 2900;
    localparam int unsigned TRIG_MIN_CYCLES = 500;
    localparam int unsigned TIMEOUT_CYCLES  = 1900000;

    // Measurement state encodings.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_TRIG_HIGH = 3'd1;
    localparam logic [2:0] ST_BURST     = 3'd2;
    localparam logic [2:0] ST_ECHO      = 3'd3;
    localparam logic [2:0] ST_HOLDOFF   = 3'd4;

    // Echo width for a latched distance; zero or beyond max_cm reports the timeout width.
    function automatic logic [ECHO_W-1:0] echo_width(
        input logic [8:0]  cm,
        input int unsigned cpm,
        input int unsigned max_cm,
        input int unsigned timeout
    );
        int unsigned cm_u;
        int unsigned w;
        cm_u = {23'd0, cm};
        if (cm_u == 0 || cm_u > max_cm) begin
            w = timeout;
        end else begin
            w = cm_u * cpm;
        end
        return w[ECHO_W-1:0];
    endfunction

endpackage

// File: rtl/usensor_trig_sync.sv
// Brings the asynchronous trig pin into the clock domain and flags its edges.
// Latency: trig_s follows the pin 2 cycles later; rise/fall are combinational from trig_s.
// Backpressure: none; edges are reported every time they occur.
module usensor_trig_sync
    import usensor_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic trig,
    output logic trig_rise,
    output logic trig_fall
);

    logic trig_meta;
    logic trig_s;
    logic trig_d;

    // Two-flop synchronizer followed by a delayed copy for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            trig_meta <= 1'b0;
            trig_s    <= 1'b0;
            trig_d    <= 1'b0;
        end else begin
            trig_meta <= trig;
            trig_s    <= trig_meta;
            trig_d    <= trig_s;
        end
    end

    assign trig_rise = trig_s & ~trig_d;
    assign trig_fall = ~trig_s & trig_d;

endmodule

// File: rtl/usensor_echo_model.sv
// Sensor-side trig/echo model: answers an accepted trig with an echo whose width encodes distance_cm.
// Latency: trig pin fall to echo rise is 3 + SETTLE_CYCLES cycles; echo lasts the latched width.
// Backpressure: trig activity outside IDLE is ignored; a held trig needs a fresh rising edge.
module usensor_echo_model
    import usensor_pkg::*;
#(
    parameter int unsigned TRIG_MIN_CYCLES = usensor_pkg::TRIG_MIN_CYCLES,
    parameter int unsigned SETTLE_CYCLES   = 10000,
    parameter int unsigned CYCLES_PER_CM   = usensor_pkg::CYCLES_PER_CM,
    parameter int unsigned MAX_CM          = 400,
    parameter int unsigned TIMEOUT_CYCLES  = usensor_pkg::TIMEOUT_CYCLES,
    parameter int unsigned HOLDOFF_CYCLES  = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       trig,
    input  logic [8:0] distance_cm,
    output logic       echo,
    output logic       busy,
    output logic       meas_done,
    output logic       short_trig
);

    localparam logic [ECHO_W-1:0] TRIG_MIN_L    = ECHO_W'(TRIG_MIN_CYCLES);
    localparam logic [ECHO_W-1:0] SETTLE_LAST   = ECHO_W'(SETTLE_CYCLES - 1);
    localparam logic [ECHO_W-1:0] HOLDOFF_LAST  = ECHO_W'(HOLDOFF_CYCLES - 1);

    logic              trig_rise;
    logic              trig_fall;
    logic [2:0]        state;
    logic [ECHO_W-1:0] cnt;
    logic [ECHO_W-1:0] width_q;

    usensor_trig_sync u_trig_sync (
        .clock     (clock),
        .reset     (reset),
        .trig      (trig),
        .trig_rise (trig_rise),
        .trig_fall (trig_fall)
    );

    // Measurement sequencer: one shared counter times trig width, settle, echo and holdoff.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            width_q    <= '0;
            echo       <= 1'b0;
            meas_done  <= 1'b0;
            short_trig <= 1'b0;
        end else begin
            meas_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (trig_rise) begin
                        state <= ST_TRIG_HIGH;
                        cnt   <= ECHO_W'(1);
                    end
                end
                ST_TRIG_HIGH: begin
                    if (trig_fall) begin
                        cnt <= '0;
                        if (cnt >= TRIG_MIN_L) begin
                            // Width is fixed here so later distance changes cannot alter this pulse.
                            width_q <= echo_width(distance_cm, CYCLES_PER_CM, MAX_CM, TIMEOUT_CYCLES);
                            state   <= ST_BURST;
                        end else begin
                            short_trig <= 1'b1;
                            state      <= ST_IDLE;
                        end
                    end else if (cnt < TRIG_MIN_L) begin
                        cnt <= cnt + ECHO_W'(1);
                    end
                end
                ST_BURST: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        echo  <= 1'b1;
                        state <= ST_ECHO;
                    end else begin
                        cnt <= cnt + ECHO_W'(1);
                    end
                end
                ST_ECHO: begin
                    if (cnt == width_q - ECHO_W'(1)) begin
                        cnt       <= '0;
                        echo      <= 1'b0;
                        meas_done <= 1'b1;
                        state     <= ST_HOLDOFF;
                    end else begin
                        cnt <= cnt + ECHO_W'(1);
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt == HOLDOFF_LAST) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + ECHO_W'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    echo  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_usensor_echo_model.sv
module tb_usensor_echo_model;

    localparam int TRIG_MIN = 8;
    localparam int SETTLE   = 20;
    localparam int CPM      = 3;
    localparam int MAXCM    = 400;
    localparam int TIMEOUT  = 1500;
    localparam int HOLDOFF  = 30;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       trig  = 1'b0;
    logic [8:0] distance_cm = 9'd0;
    logic       echo;
    logic       busy;
    logic       meas_done;
    logic       short_trig;

    usensor_echo_model #(
        .TRIG_MIN_CYCLES (TRIG_MIN),
        .SETTLE_CYCLES   (SETTLE),
        .CYCLES_PER_CM   (CPM),
        .MAX_CM          (MAXCM),
        .TIMEOUT_CYCLES  (TIMEOUT),
        .HOLDOFF_CYCLES  (HOLDOFF)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .trig        (trig),
        .distance_cm (distance_cm),
        .echo        (echo),
        .busy        (busy),
        .meas_done   (meas_done),
        .short_trig  (short_trig)
    );

    always #5 clock = ~clock;

    typedef struct {
        int w;
        int rise_at;
    } exp_t;

    exp_t sb[$];
    int   cyc         = 0;
    int   n_tests     = 0;
    int   n_fail      = 0;
    int   done_pulses = 0;
    int   exp_done    = 0;
    int   stray       = 0;
    int   rise_cyc    = 0;
    logic prev_echo   = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic int model_w(input int cm);
        if (cm == 0 || cm > MAXCM) return TIMEOUT;
        return cm * CPM;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Echo monitor: checks rise time and width against the scoreboard head.
    always @(negedge clock) begin
        if (reset) begin
            prev_echo = 1'b0;
        end else begin
            if (meas_done) done_pulses++;
            if (echo && !prev_echo) begin
                rise_cyc = cyc;
                if (sb.size() == 0) stray++;
                else chk("echo_rise_cycle", cyc, sb[0].rise_at);
            end
            if (!echo && prev_echo) begin
                chk("meas_done_on_fall", int'(meas_done), 1);
                if (sb.size() != 0) begin
                    chk("echo_width", cyc - rise_cyc, sb[0].w);
                    void'(sb.pop_front());
                end
            end
            prev_echo = echo;
        end
    end

    task automatic pulse(input int hi, input bit idle_expected);
        @(negedge clock);
        trig = 1'b1;
        repeat (hi) @(negedge clock);
        trig = 1'b0;
        if (idle_expected && hi >= TRIG_MIN) begin
            sb.push_back('{model_w(int'(distance_cm)), cyc + 3 + SETTLE});
            exp_done++;
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk(tag, int'(n < budget), 1);
    endtask

    task automatic wait_echo(input string tag, input logic level, input int budget);
        int n = 0;
        while (echo !== level && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk(tag, int'(n < budget), 1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_echo", int'(echo), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_meas_done", int'(meas_done), 0);
        chk("rst_short_trig", int'(short_trig), 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Normal measurement
        distance_cm = 9'd50;
        pulse(40, 1'b1);
        chk("busy_after_trig", int'(busy), 1);
        wait_done("normal_done", 3000);
        chk("normal_no_short", int'(short_trig), 0);

        // Short trig one below the minimum is rejected
        pulse(TRIG_MIN - 1, 1'b1);
        repeat (6) @(negedge clock);
        chk("short_busy_low", int'(busy), 0);
        chk("short_flag_set", int'(short_trig), 1);

        // Trig exactly at the minimum is accepted; short flag stays sticky
        distance_cm = 9'd1;
        pulse(TRIG_MIN, 1'b1);
        wait_done("min_trig_done", 3000);
        chk("short_flag_sticky", int'(short_trig), 1);

        // Out of range and range boundary
        distance_cm = 9'd0;
        pulse(12, 1'b1);
        wait_done("zero_cm_done", 3000);
        distance_cm = 9'd450;
        pulse(12, 1'b1);
        wait_done("far_cm_done", 3000);
        distance_cm = 9'd400;
        pulse(12, 1'b1);
        wait_done("max_cm_done", 3000);

        // Retrigger during echo, then trig held through holdoff
        distance_cm = 9'd10;
        pulse(20, 1'b1);
        wait_echo("retrig_rise", 1'b1, 200);
        repeat (5) @(negedge clock);
        pulse(10, 1'b0);
        wait_echo("retrig_fall", 1'b0, 200);
        trig = 1'b1;
        repeat (HOLDOFF + 15) @(negedge clock);
        chk("held_trig_ignored", int'(busy), 0);
        trig = 1'b0;
        repeat (5) @(negedge clock);
        chk("held_trig_release", int'(busy), 0);
        pulse(20, 1'b1);
        wait_done("fresh_trig_done", 3000);

        // Distance change after latch
        distance_cm = 9'd20;
        pulse(20, 1'b1);
        repeat (5) @(negedge clock);
        distance_cm = 9'd300;
        wait_done("late_change_done", 3000);
        pulse(20, 1'b1);
        wait_done("next_meas_done", 3000);

        // Reset in the middle of an echo
        distance_cm = 9'd100;
        pulse(20, 1'b1);
        wait_echo("rst_mid_rise", 1'b1, 200);
        repeat (10) @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_echo_async", int'(echo), 0);
        chk("rst_mid_busy", int'(busy), 0);
        sb.delete();
        exp_done--;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("post_rst_idle", int'(busy), 0);
        chk("post_rst_short_clear", int'(short_trig), 0);
        distance_cm = 9'd1;
        pulse(20, 1'b1);
        wait_done("post_rst_done", 3000);

        repeat (5) @(negedge clock);
        chk("meas_done_count", done_pulses, exp_done);
        chk("stray_echoes", stray, 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
